// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: grant in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [N-1:0] alu_i1,
    output logic [N-1:0] alu_i2,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]   op_q, op_d;
    logic         id_q, id_d, last_q, last_d, zero_q, zero_d;
    logic         gnt_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        last_d    = last_q;
        res_d     = res_q;
        zero_d    = zero_q;
        gnt_id    = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // req_ready is combinational, so it must also be held low while reset is asserted
                if (rst_n && (req_valid != 2'b00)) begin
                    // On a tie the requester not granted last wins
                    gnt_id    = (req_valid == 2'b10) || ((req_valid == 2'b11) && !last_q);
                    req_ready = gnt_id ? 2'b10 : 2'b01;
                    a_d       = gnt_id ? req1_a  : req0_a;
                    b_d       = gnt_id ? req1_b  : req0_b;
                    op_d      = gnt_id ? req1_op : req0_op;
                    id_d      = gnt_id;
                    last_d    = gnt_id;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_i1     = a_q;
    assign alu_i2     = b_q;
    assign alu_op     = op_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  bit i = requester i has an operation pending.
REQ-005 req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N each  operands of requester 0 / 1.
REQ-007 req0_op / req1_op  input  3 each  ALU opcode of requester 0 / 1.
REQ-008 alu_i1, alu_i2  output  N each  operands driven to the shared ALU.
REQ-009 alu_op  output  3  opcode driven to the shared ALU.
REQ-010 alu_result  input  N, alu_zero  input  1  combinational ALU outputs.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_id  output  1  requester index the response belongs to.
REQ-014 rsp_result  output  N, rsp_zero  output  1  captured ALU outputs.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; one ALU operation in flight at a time.
REQ-016 In IDLE, if any req_valid bit is set, the block SHALL grant exactly one requester via a single-cycle req_ready pulse, capture its a, b, op into internal operand registers and its index into rsp_id, and move to EXEC.
REQ-017 req_ready SHALL be 0 in EXEC and RESP and 0 for non-granted requesters; req_ready[i] SHALL never assert without req_valid[i].
REQ-018 Arbitration SHALL be round-robin: single requester valid -> it wins; both valid -> the one not granted last wins; last-grant register resets to 1 so requester 0 wins the first tie.
REQ-019 alu_i1, alu_i2, alu_op SHALL always be driven from the operand registers (not from requester inputs).
REQ-020 In EXEC (exactly one cycle) the block SHALL capture alu_result into rsp_result and alu_zero into rsp_zero and move to RESP.
REQ-021 In RESP rsp_valid SHALL be 1; rsp_result, rsp_zero, rsp_id SHALL be stable until rsp_valid&rsp_ready.
REQ-022 On rsp_valid&rsp_ready the block SHALL deassert rsp_valid next cycle and return to IDLE; minimum grant-to-grant spacing 3 cycles.
REQ-023 rsp_ready held 0 SHALL stall indefinitely in RESP with no new grants; pending requesters SHALL keep waiting, none dropped.
REQ-024 A req_valid deasserted before its grant SHALL be ignored with no state change.
REQ-025 Operand width handling SHALL be pass-through at N bits; no truncation or extension.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, rsp_valid=0, req_ready=0, operand registers=0 (alu_i1=alu_i2=0, alu_op=3'b000), rsp_result=0, rsp_zero=0, rsp_id=0, last-grant=1.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be produced for it after release.
REQ-028 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification (bench ALU stub: result = i1 + i2, zero = result==0)
REQ-029 Reset -> all outputs at REQ-026 values, checked while rst_n low and one cycle after release.
REQ-030 Only req_valid=2'b01, a=16'h0003, b=16'h0004, rsp_ready=1 -> req_ready=2'b01 one cycle, rsp_valid two cycles later with rsp_result=16'h0007, rsp_zero=0, rsp_id=0.
REQ-031 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; grants spaced exactly 3 cycles.
REQ-032 req1 a=16'hFFFF, b=16'h0001, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_result=16'h0000, rsp_zero=1 stable, req_ready stays 2'b00; completes the cycle rsp_ready rises.
REQ-033 rst_n pulsed low while in RESP -> rsp_valid falls asynchronously, no response for that op after release, next grant goes to requester 0 on tie.
REQ-034 req_valid[0] pulsed high one cycle during RESP then dropped -> never granted, no extra response.
